// File: rtl/p2s_rr_sched.sv
// ---------------------------------------------------------------------------
// p2s_rr_sched
//   Round-robin scheduler in front of one shared parallel-to-serial shift
//   engine. NCH channels offer W-bit words over valid/ready; the granted word
//   is sent MSB first, one bit per clock, tagged with a frame-sync pulse and
//   the source channel ID. An optional forced idle gap separates frames.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   req_valid   [NCH]     per-channel word available
//   req_data    [NCH*W]   channel i word at bits [i*W +: W]
//   req_ready   [NCH]     one-hot grant (combinational), 0 while rst is high
//   dout                  serial data, MSB first
//   fs                    high only in the MSB cycle of a frame
//   ch_id       [CW]      source channel of the current/last frame
//   count       [5]       bit index within the frame (0 = MSB)
//   busy                  high while a frame bit is on dout
//   frame_done            one-cycle pulse in the last-bit cycle
// ---------------------------------------------------------------------------

// Per-channel slice: extracts the lane word and qualifies the grant into a
// ready strobe for that channel.
module p2s_rr_lane #(
   parameter int W = 16
) (
   input  logic         gnt,
   input  logic         arb_en,
   input  logic [W-1:0] data_in,
   output logic         ready,
   output logic [W-1:0] word
);
   assign ready = gnt & arb_en;
   assign word  = data_in;
endmodule

module p2s_rr_sched #(
   parameter int NCH = 4,
   parameter int W   = 16,
   parameter int GAP = 0,
   parameter int CW  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   req_valid,
   input  logic [NCH*W-1:0] req_data,
   output logic [NCH-1:0]   req_ready,
   output logic             dout,
   output logic             fs,
   output logic [CW-1:0]    ch_id,
   output logic [4:0]       count,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      SHIFT = 2'd1,
      GAPS  = 2'd2
   } state_t;

   localparam logic [4:0] LAST   = 5'(W-1);
   localparam logic [3:0] GAP_M1 = (GAP > 0) ? 4'(GAP-1) : 4'd0;

   state_t                  state;
   logic [CW-1:0]           rr_ptr;
   logic [W-1:0]            sreg;
   logic [3:0]              gap_cnt;

   logic                    last_bit;
   logic                    arb_cyc;
   logic                    arb_en;
   logic                    xfer;
   logic [NCH-1:0]          gnt;
   logic [CW-1:0]           gnt_idx;
   logic [CW-1:0]           rr_next;
   logic [NCH-1:0][W-1:0]   lane_data;

   assign last_bit = (state == SHIFT) && (count == LAST);

   // Arbitration happens in idle, in the last bit of a frame when there is
   // no forced gap (zero dead cycles), or in the last gap cycle.
   always_comb begin
      arb_cyc = 1'b0;
      case (state)
         ARB:     arb_cyc = 1'b1;
         SHIFT:   arb_cyc = last_bit && (GAP == 0);
         GAPS:    arb_cyc = (gap_cnt == 4'd0);
         default: arb_cyc = 1'b0;
      endcase
   end

   assign arb_en = arb_cyc & ~rst;

   // Rotating priority search: first valid channel at or above rr_ptr,
   // wrapping mod NCH. Works for non-power-of-two NCH.
   always_comb begin
      int  idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < NCH; k++) begin
         idx = (int'(rr_ptr) + k) % NCH;
         if (!found && req_valid[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = CW'(idx);
         end
      end
   end

   generate
      for (genvar i = 0; i < NCH; i++) begin : g_lane
         p2s_rr_lane #(.W(W)) u_lane (
            .gnt     (gnt[i]),
            .arb_en  (arb_en),
            .data_in (req_data[i*W +: W]),
            .ready   (req_ready[i]),
            .word    (lane_data[i])
         );
      end
   endgenerate

   // gnt only ever marks a valid channel, so any ready bit is a transfer.
   assign xfer    = |req_ready;
   assign rr_next = (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB;
         rr_ptr     <= '0;
         sreg       <= '0;
         gap_cnt    <= '0;
         ch_id      <= '0;
         count      <= '0;
         dout       <= 1'b0;
         fs         <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         fs         <= 1'b0;
         frame_done <= 1'b0;
         if (xfer) begin
            // MSB goes straight to dout; the register holds the remaining
            // bits already shifted up so dout always follows sreg[W-1].
            state      <= SHIFT;
            dout       <= lane_data[gnt_idx][W-1];
            sreg       <= lane_data[gnt_idx] << 1;
            ch_id      <= gnt_idx;
            rr_ptr     <= rr_next;
            count      <= '0;
            fs         <= 1'b1;
            busy       <= 1'b1;
            frame_done <= (W == 1);
         end else begin
            case (state)
               SHIFT: begin
                  if (!last_bit) begin
                     dout       <= sreg[W-1];
                     sreg       <= sreg << 1;
                     count      <= count + 5'd1;
                     frame_done <= (count + 5'd1 == LAST);
                  end else begin
                     dout  <= 1'b0;
                     busy  <= 1'b0;
                     count <= '0;
                     if (GAP > 0) begin
                        state   <= GAPS;
                        gap_cnt <= GAP_M1;
                     end else begin
                        state <= ARB;
                     end
                  end
               end
               GAPS: begin
                  if (gap_cnt == 4'd0) state <= ARB;
                  else                 gap_cnt <= gap_cnt - 4'd1;
               end
               default: state <= ARB;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_p2s_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_p2s_rr_sched
//   Two scheduler instances (GAP = 0 and GAP = 3) share one clock and reset
//   and see the same kind of producer traffic. A reference model tracks, per
//   instance, the number of cycles until the next arbitration opportunity and
//   a round-robin pointer; it predicts each grant and queues the expected
//   frame. A monitor pops the queue whenever a frame starts and checks every
//   serial cycle, the idle cycles between frames, and the reset behaviour.
// ---------------------------------------------------------------------------
module tb_p2s_rr_sched;
   localparam int NCH = 4;
   localparam int W   = 16;
   localparam int CW  = 2;
   localparam int ND  = 2;

   typedef struct {
      int           ch;
      logic [W-1:0] word;
      int           start;
   } frame_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   vld  [ND];
   logic [NCH*W-1:0] dat  [ND];
   logic [NCH-1:0]   rdy  [ND];
   logic             dout [ND];
   logic             fs   [ND];
   logic             busy [ND];
   logic             fdone[ND];
   logic [CW-1:0]    chid [ND];
   logic [4:0]       cnt  [ND];
   logic [NCH-1:0]   cont;
   logic             finish_req = 1'b0;

   int               n_chk = 0;
   int               n_fail = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < ND; g++) begin : g_dut
         p2s_rr_sched #(.NCH(NCH), .W(W), .GAP(g == 0 ? 0 : 3), .CW(CW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (vld[g]),
            .req_data   (dat[g]),
            .req_ready  (rdy[g]),
            .dout       (dout[g]),
            .fs         (fs[g]),
            .ch_id      (chid[g]),
            .count      (cnt[g]),
            .busy       (busy[g]),
            .frame_done (fdone[g])
         );
      end
   endgenerate

   function automatic int gap_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // ---------------- reference model ----------------
   int       left [ND];
   int       rr   [ND];
   int       cyc;
   logic [NCH-1:0] exp_rdy [ND];
   frame_t   sb [ND][$];

   initial begin
      int     c, gc;
      frame_t f;
      cyc = 0;
      for (int d = 0; d < ND; d++) begin
         left[d] = 0; rr[d] = 0; exp_rdy[d] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < ND; d++) begin
            exp_rdy[d] = '0;
            if (rst) begin
               left[d] = 0;
               rr[d]   = 0;
               sb[d].delete();
            end else begin
               if (left[d] > 0) left[d]--;
               if (left[d] == 0) begin
                  gc = -1;
                  for (int k = 0; k < NCH; k++) begin
                     c = (rr[d] + k) % NCH;
                     if (gc < 0 && vld[d][c]) gc = c;
                  end
                  if (gc >= 0) begin
                     exp_rdy[d][gc] = 1'b1;
                     f.ch    = gc;
                     f.word  = dat[d][gc*W +: W];
                     f.start = cyc + 1;
                     sb[d].push_back(f);
                     rr[d]   = (gc + 1) % NCH;
                     left[d] = W + gap_of(d);
                  end
               end
            end
         end
      end
   end

   // ---------------- monitor ----------------
   function automatic void chk(input string nm, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, d, cyc, act, exp);
      end
   endfunction

   bit     in_frame [ND];
   int     kb       [ND];
   int     last_ch  [ND];
   frame_t cur      [ND];

   initial begin
      for (int d = 0; d < ND; d++) begin
         in_frame[d] = 1'b0; kb[d] = 0; last_ch[d] = 0;
      end
      while (!finish_req) begin
         @(negedge clk); #1;
         for (int d = 0; d < ND; d++) begin
            if (rst) begin
               chk("rst_ready", d, 32'(rdy[d]), 0);
               chk("rst_dout",  d, 32'(dout[d]), 0);
               chk("rst_fs",    d, 32'(fs[d]), 0);
               chk("rst_busy",  d, 32'(busy[d]), 0);
               chk("rst_count", d, 32'(cnt[d]), 0);
               chk("rst_done",  d, 32'(fdone[d]), 0);
               chk("rst_chid",  d, 32'(chid[d]), 0);
               in_frame[d] = 1'b0;
               last_ch[d]  = 0;
            end else begin
               chk("grant", d, 32'(rdy[d]), 32'(exp_rdy[d]));
               if (!in_frame[d] && fs[d]) begin
                  if (sb[d].size() == 0) begin
                     chk("fs_without_grant", d, 32'(fs[d]), 0);
                  end else begin
                     cur[d] = sb[d].pop_front();
                     chk("frame_start", d, cyc, cur[d].start);
                     in_frame[d] = 1'b1;
                     kb[d]       = 0;
                     last_ch[d]  = cur[d].ch;
                  end
               end
               if (in_frame[d]) begin
                  chk("dout",  d, 32'(dout[d]), 32'(cur[d].word[W-1-kb[d]]));
                  chk("count", d, 32'(cnt[d]), kb[d]);
                  chk("busy",  d, 32'(busy[d]), 1);
                  chk("fs",    d, 32'(fs[d]), (kb[d] == 0) ? 1 : 0);
                  chk("done",  d, 32'(fdone[d]), (kb[d] == W-1) ? 1 : 0);
                  chk("ch_id", d, 32'(chid[d]), cur[d].ch);
                  kb[d]++;
                  if (kb[d] == W) in_frame[d] = 1'b0;
               end else begin
                  chk("idle_dout",  d, 32'(dout[d]), 0);
                  chk("idle_busy",  d, 32'(busy[d]), 0);
                  chk("idle_fs",    d, 32'(fs[d]), 0);
                  chk("idle_count", d, 32'(cnt[d]), 0);
                  chk("idle_done",  d, 32'(fdone[d]), 0);
                  chk("idle_chid",  d, 32'(chid[d]), last_ch[d]);
                  if (sb[d].size() > 0 && sb[d][0].start <= cyc) begin
                     chk("frame_missing", d, 32'(fs[d]), 1);
                     void'(sb[d].pop_front());
                  end
               end
            end
         end
      end
      for (int d = 0; d < ND; d++) begin
         chk("sb_empty",   d, 32'(sb[d].size()), 0);
         chk("frame_open", d, 32'(in_frame[d]), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // ---------------- stimulus ----------------
   // One clock: note which channels transferred at the edge, then let the
   // producers react (continuous channels offer a fresh word, others drop).
   task automatic step();
      logic [NCH-1:0] xf [ND];
      @(negedge clk);
      for (int d = 0; d < ND; d++) xf[d] = vld[d] & rdy[d];
      @(posedge clk); #1;
      for (int d = 0; d < ND; d++)
         for (int i = 0; i < NCH; i++)
            if (xf[d][i]) begin
               if (cont[i]) dat[d][i*W +: W] = W'($urandom);
               else         vld[d][i] = 1'b0;
            end
   endtask

   task automatic steps(input int n);
      for (int j = 0; j < n; j++) step();
   endtask

   task automatic offer(input int i, input logic [W-1:0] w);
      for (int d = 0; d < ND; d++) begin
         dat[d][i*W +: W] = w;
         vld[d][i]        = 1'b1;
      end
   endtask

   task automatic drop_all();
      for (int d = 0; d < ND; d++) vld[d] = '0;
      cont = '0;
   endtask

   initial begin
      for (int d = 0; d < ND; d++) begin
         vld[d] = '0;
         dat[d] = '0;
      end
      cont = '0;
      rst  = 1'b1;
      steps(3);
      rst = 1'b0;
      steps(2);

      // single request
      offer(1, 16'hA5C3);
      steps(25);

      // two channels contending, held until served
      offer(0, 16'h1111);
      offer(2, 16'hFFFF);
      steps(45);

      // fairness: everyone continuously valid
      cont = 4'hF;
      for (int i = 0; i < NCH; i++) offer(i, W'($urandom));
      steps(8 * 16 + 4);
      drop_all();
      steps(30);

      // one continuous channel (exposes the forced gap on instance 1)
      cont = 4'b1000;
      offer(3, W'($urandom));
      steps(70);
      drop_all();
      steps(30);

      // withdrawn request while a frame is shifting
      offer(0, 16'h5A0F);
      steps(3);
      for (int d = 0; d < ND; d++) vld[d][1] = 1'b1;
      step();
      for (int d = 0; d < ND; d++) vld[d][1] = 1'b0;
      steps(30);

      // reset in the middle of a frame (bit 7), then restart with pointer 0
      offer(0, 16'hC3A5);
      steps(8);
      #1 rst = 1'b1;
      steps(1);
      offer(3, 16'h0F0F);
      offer(0, 16'h8001);
      steps(1);
      rst = 1'b0;
      steps(45);

      // randomized traffic
      cont = NCH'($urandom);
      for (int n = 0; n < 300; n++) begin
         for (int d = 0; d < ND; d++)
            for (int i = 0; i < NCH; i++) begin
               if (!vld[d][i]) begin
                  if ($urandom_range(3) == 0) begin
                     vld[d][i]        = 1'b1;
                     dat[d][i*W +: W] = W'($urandom);
                  end
               end else if ($urandom_range(15) == 0) begin
                  vld[d][i] = 1'b0;
               end
            end
         step();
      end
      drop_all();
      steps(60);
      finish_req = 1'b1;
   end

endmodule
